// File: rtl/cache_fe_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the cache
// front-end native port. Master-side fields are packed, master i at slice i.
interface cache_fe_arbiter_if #(
   parameter int N_MASTERS = 2,
   parameter int AW        = 32,
   parameter int FE_DATA_W = 32,
   parameter int FE_NBYTES = FE_DATA_W/8
);
   // requester side
   logic [N_MASTERS-1:0]           m_valid;
   logic [N_MASTERS*AW-1:0]        m_addr;
   logic [N_MASTERS*FE_DATA_W-1:0] m_wdata;
   logic [N_MASTERS*FE_NBYTES-1:0] m_wstrb;
   logic [FE_DATA_W-1:0]           m_rdata;
   logic [N_MASTERS-1:0]           m_ready;
   // cache side
   logic                           s_valid;
   logic [AW-1:0]                  s_addr;
   logic [FE_DATA_W-1:0]           s_wdata;
   logic [FE_NBYTES-1:0]           s_wstrb;
   logic [FE_DATA_W-1:0]           s_rdata;
   logic                           s_ready;

   // arbiter view: consumes requests and cache response, drives both sides
   modport arb (
      input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
      output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
   );

   // requester view
   modport master (
      output m_valid, m_addr, m_wdata, m_wstrb,
      input  m_rdata, m_ready
   );

   // cache view
   modport slave (
      input  s_valid, s_addr, s_wdata, s_wstrb,
      output s_rdata, s_ready
   );
endinterface

// File: rtl/cache_fe_arbiter.sv
// Shares one cache front-end port between N_MASTERS requesters. The winning
// request is registered and held on the cache port until s_ready; ready and
// rdata are routed back combinationally to the owner. One bubble cycle
// follows every completion.
module cache_fe_arbiter #(
   parameter int N_MASTERS  = 2,
   parameter int FE_ADDR_W  = 32,
   parameter int FE_DATA_W  = 32,
   parameter int CTRL_CACHE = 0,
   parameter int ARB_MODE   = 0,
   parameter int FE_NBYTES  = FE_DATA_W/8
) (
   input  logic                 clk,
   input  logic                 reset,
   cache_fe_arbiter_if.arb      bus,
   output logic [N_MASTERS-1:0] grant,
   output logic                 busy
);
   localparam int AW = CTRL_CACHE + FE_ADDR_W;
   localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t               state_q;
   logic                 s_valid_q;
   logic [AW-1:0]        s_addr_q;
   logic [FE_DATA_W-1:0] s_wdata_q;
   logic [FE_NBYTES-1:0] s_wstrb_q;
   logic [N_MASTERS-1:0] grant_q;
   logic                 busy_q;
   logic [IW-1:0]        last_q;
   logic [IW-1:0]        win_q;

   logic [IW-1:0]        win_d;
   logic [N_MASTERS-1:0] grant_d;
   logic [AW-1:0]        addr_d;
   logic [FE_DATA_W-1:0] wdata_d;
   logic [FE_NBYTES-1:0] wstrb_d;
   logic                 any_req;

   // Index that is k positions after base, wrapping at N_MASTERS.
   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
      return IW'((int'(base) + k) % N_MASTERS);
   endfunction

   assign any_req = |bus.m_valid;

   // Winner selection. Both loops run so that the preferred candidate is
   // written last: fixed priority scans high to low, round-robin scans from
   // the farthest position after last back to the nearest one.
   always_comb begin
      win_d = '0;
      if (ARB_MODE == 1) begin
         for (int k = N_MASTERS - 1; k >= 0; k--)
            if (bus.m_valid[k]) win_d = IW'(k);
      end else begin
         for (int k = N_MASTERS; k >= 1; k--)
            if (bus.m_valid[rr_idx(last_q, k)]) win_d = rr_idx(last_q, k);
      end
   end

   assign grant_d = N_MASTERS'(1) << win_d;
   assign addr_d  = bus.m_addr [win_d*AW        +: AW];
   assign wdata_d = bus.m_wdata[win_d*FE_DATA_W +: FE_DATA_W];
   assign wstrb_d = bus.m_wstrb[win_d*FE_NBYTES +: FE_NBYTES];

   // Access FSM: capture the winner in IDLE, hold everything in BUSY until
   // the cache completes. Reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         s_valid_q <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_wstrb_q <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         last_q    <= IW'(N_MASTERS - 1);
         win_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  s_addr_q  <= addr_d;
                  s_wdata_q <= wdata_d;
                  s_wstrb_q <= wstrb_d;
                  grant_q   <= grant_d;
                  win_q     <= win_d;
                  s_valid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               if (bus.s_ready) begin
                  s_valid_q <= 1'b0;
                  grant_q   <= '0;
                  busy_q    <= 1'b0;
                  last_q    <= win_q;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // grant is zero outside BUSY, so a stray s_ready in IDLE reaches nobody
   assign bus.m_ready = grant_q & {N_MASTERS{bus.s_ready}};
   assign bus.m_rdata = bus.s_rdata;
   assign bus.s_valid = s_valid_q;
   assign bus.s_addr  = s_addr_q;
   assign bus.s_wdata = s_wdata_q;
   assign bus.s_wstrb = s_wstrb_q;
   assign grant       = grant_q;
   assign busy        = busy_q;
endmodule

// File: tb/tb_cache_fe_arbiter.sv
// Bench for cache_fe_arbiter: a round-robin and a fixed-priority instance,
// directed sequences, a vector table, and a random phase checked against a
// transaction-level reference model.
module tb_cache_fe_arbiter;
   localparam int NM = 2, AW = 32, DW = 32, NB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // per-instance stimulus (0 = round-robin, 1 = fixed priority)
   logic [NM-1:0]    tb_mv  [2];
   logic [NM*AW-1:0] tb_ma  [2];
   logic [NM*DW-1:0] tb_mw  [2];
   logic [NM*NB-1:0] tb_ms  [2];
   logic [DW-1:0]    tb_sr  [2];
   logic             tb_srdy[2];

   logic [NM-1:0] o_rdy [2];
   logic [NM-1:0] o_gnt [2];
   logic          o_busy[2];
   logic          o_sv  [2];
   logic [DW-1:0] o_rdata[2];
   logic [DW-1:0] o_sw  [2];
   logic [AW-1:0] o_sa  [2];
   logic [NB-1:0] o_ss  [2];

   cache_fe_arbiter_if #(.N_MASTERS(NM), .AW(AW), .FE_DATA_W(DW)) bus0 ();
   cache_fe_arbiter_if #(.N_MASTERS(NM), .AW(AW), .FE_DATA_W(DW)) bus1 ();

   assign bus0.m_valid = tb_mv[0];  assign bus1.m_valid = tb_mv[1];
   assign bus0.m_addr  = tb_ma[0];  assign bus1.m_addr  = tb_ma[1];
   assign bus0.m_wdata = tb_mw[0];  assign bus1.m_wdata = tb_mw[1];
   assign bus0.m_wstrb = tb_ms[0];  assign bus1.m_wstrb = tb_ms[1];
   assign bus0.s_rdata = tb_sr[0];  assign bus1.s_rdata = tb_sr[1];
   assign bus0.s_ready = tb_srdy[0]; assign bus1.s_ready = tb_srdy[1];

   assign o_rdy[0]   = bus0.m_ready; assign o_rdy[1]   = bus1.m_ready;
   assign o_sv[0]    = bus0.s_valid; assign o_sv[1]    = bus1.s_valid;
   assign o_rdata[0] = bus0.m_rdata; assign o_rdata[1] = bus1.m_rdata;
   assign o_sa[0]    = bus0.s_addr;  assign o_sa[1]    = bus1.s_addr;
   assign o_sw[0]    = bus0.s_wdata; assign o_sw[1]    = bus1.s_wdata;
   assign o_ss[0]    = bus0.s_wstrb; assign o_ss[1]    = bus1.s_wstrb;

   cache_fe_arbiter #(.N_MASTERS(NM), .FE_ADDR_W(AW), .FE_DATA_W(DW),
                      .CTRL_CACHE(0), .ARB_MODE(0)) dut_rr (
      .clk(clk), .reset(rst_n), .bus(bus0), .grant(o_gnt[0]), .busy(o_busy[0]));

   cache_fe_arbiter #(.N_MASTERS(NM), .FE_ADDR_W(AW), .FE_DATA_W(DW),
                      .CTRL_CACHE(0), .ARB_MODE(1)) dut_fp (
      .clk(clk), .reset(rst_n), .bus(bus1), .grant(o_gnt[1]), .busy(o_busy[1]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int d = 0; d < 2; d++) begin
         tb_mv[d] = '0; tb_ma[d] = '0; tb_mw[d] = '0; tb_ms[d] = '0;
         tb_sr[d] = '0; tb_srdy[d] = 1'b0;
      end
   endtask

   // leaves the bench one delta after a rising edge, reset released
   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // reference arbitration: who gets the port given requests and last owner
   function automatic int pick(input int mode, input logic [NM-1:0] v, input int last);
      if (mode == 1) begin
         for (int i = 0; i < NM; i++) if (v[i]) return i;
      end else begin
         for (int k = 1; k <= NM; k++) if (v[(last + k) % NM]) return (last + k) % NM;
      end
      return -1;
   endfunction

   typedef struct {
      logic [NM-1:0] mv;
      logic          srdy;
      logic [NM-1:0] g_rr, r_rr, g_fp, r_fp;
      logic          bsy;
   } vec_t;
   vec_t vec[11];

   // reference model state for the random phase
   int            mbusy[2], own[2], lst[2];
   logic [AW-1:0] caddr[2];
   logic [DW-1:0] cwd[2];
   logic [NB-1:0] cst[2];
   bit            pend[2][NM];
   logic [NM-1:0] exp_gr, exp_rdy;

   initial begin
      clear_inputs();
      rst_n = 1'b0;

      // ---- reset state, then single read on the round-robin instance
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d s_valid", d), o_sv[d], 0);
         chk($sformatf("rst%0d grant", d), o_gnt[d], 0);
         chk($sformatf("rst%0d busy", d), o_busy[d], 0);
         chk($sformatf("rst%0d s_addr", d), o_sa[d], 0);
         chk($sformatf("rst%0d s_wstrb", d), o_ss[d], 0);
      end
      rst_n = 1'b1;
      tb_mv[0] = 2'b01; tb_ma[0] = 64'h0000_0000_0000_0040; tb_ms[0] = '0;
      @(negedge clk);
      chk("single s_valid before grant", o_sv[0], 0);
      @(posedge clk); #1;
      tb_srdy[0] = 1'b1; tb_sr[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("single s_valid", o_sv[0], 1);
      chk("single s_addr", o_sa[0], 32'h40);
      chk("single m_ready", o_rdy[0], 2'b01);
      chk("single m_rdata", o_rdata[0], 32'hDEAD_BEEF);
      @(posedge clk); #1;
      tb_mv[0] = '0; tb_srdy[0] = 1'b0;
      @(negedge clk);
      chk("single grant after", o_gnt[0], 0);
      chk("single busy after", o_busy[0], 0);

      // ---- vector table: both masters requesting, both instances in step
      vec[0]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      vec[1]  = '{2'b11, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1};
      vec[2]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      vec[3]  = '{2'b11, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b1};
      vec[4]  = '{2'b11, 1'b1, 2'b10, 2'b10, 2'b01, 2'b01, 1'b1};
      vec[5]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      vec[6]  = '{2'b11, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1};
      vec[7]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      vec[8]  = '{2'b11, 1'b1, 2'b10, 2'b10, 2'b01, 2'b01, 1'b1};
      vec[9]  = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      vec[10] = '{2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         for (int d = 0; d < 2; d++) begin
            tb_mv[d] = vec[i].mv; tb_srdy[d] = vec[i].srdy;
            tb_sr[d] = 32'hA000_0000 + 32'(i);
            tb_ma[d] = {32'h0000_0200, 32'h0000_0100};
         end
         @(negedge clk);
         chk($sformatf("vec%0d rr grant", i), o_gnt[0], vec[i].g_rr);
         chk($sformatf("vec%0d rr m_ready", i), o_rdy[0], vec[i].r_rr);
         chk($sformatf("vec%0d rr busy", i), o_busy[0], vec[i].bsy);
         chk($sformatf("vec%0d rr s_valid", i), o_sv[0], vec[i].bsy);
         chk($sformatf("vec%0d fp grant", i), o_gnt[1], vec[i].g_fp);
         chk($sformatf("vec%0d fp m_ready", i), o_rdy[1], vec[i].r_fp);
         chk($sformatf("vec%0d fp busy", i), o_busy[1], vec[i].bsy);
         chk($sformatf("vec%0d rdata", i), o_rdata[0], 32'hA000_0000 + 32'(i));
         if (vec[i].bsy) begin
            chk($sformatf("vec%0d rr s_addr", i), o_sa[0],
                (vec[i].g_rr == 2'b01) ? 32'h100 : 32'h200);
            chk($sformatf("vec%0d fp s_addr", i), o_sa[1], 32'h100);
         end
         @(posedge clk); #1;
      end

      // ---- write capture and hold over a slow cache response
      tb_mv[0] = 2'b10; tb_ma[0] = {32'h0000_0080, 32'h0};
      tb_mw[0] = {32'h1234_5678, 32'h0}; tb_ms[0] = {4'hF, 4'h0}; tb_srdy[0] = 1'b0;
      @(posedge clk); #1;
      tb_mw[0][63:32] = 32'h0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d s_valid", k), o_sv[0], 1);
         chk($sformatf("hold%0d s_wdata", k), o_sw[0], 32'h1234_5678);
         chk($sformatf("hold%0d s_wstrb", k), o_ss[0], 4'hF);
         chk($sformatf("hold%0d s_addr", k), o_sa[0], 32'h80);
         chk($sformatf("hold%0d m_ready", k), o_rdy[0], 0);
         @(posedge clk); #1;
      end
      tb_srdy[0] = 1'b1;
      @(negedge clk);
      chk("hold m_ready", o_rdy[0], 2'b10);
      @(posedge clk); #1;
      tb_mv[0] = '0; tb_srdy[0] = 1'b0;

      // ---- fixed priority: master 1 waits until master 0 drops
      tb_mv[1] = 2'b11; tb_srdy[1] = 1'b0;
      @(negedge clk);
      chk("fp idle grant", o_gnt[1], 0);
      @(posedge clk); #1;
      tb_srdy[1] = 1'b1;
      @(negedge clk);
      chk("fp first grant", o_gnt[1], 2'b01);
      chk("fp first m_ready", o_rdy[1], 2'b01);
      @(posedge clk); #1;
      tb_mv[1] = 2'b10; tb_srdy[1] = 1'b0;
      @(negedge clk);
      chk("fp bubble grant", o_gnt[1], 0);
      @(posedge clk); #1;
      tb_srdy[1] = 1'b1;
      @(negedge clk);
      chk("fp m1 grant", o_gnt[1], 2'b10);
      chk("fp m1 m_ready", o_rdy[1], 2'b10);
      @(posedge clk); #1;
      tb_mv[1] = '0; tb_srdy[1] = 1'b0;

      // ---- reset during an access: master 0 completes (last=0), then
      //      master 1 is cut off; after reset master 0 must win again
      tb_mv[0] = 2'b01;
      @(posedge clk); #1;
      tb_srdy[0] = 1'b1;
      @(negedge clk);
      chk("mrst pre m_ready", o_rdy[0], 2'b01);
      @(posedge clk); #1;
      tb_mv[0] = 2'b10; tb_srdy[0] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mrst busy grant", o_gnt[0], 2'b10);
      #2;
      rst_n = 1'b0; tb_srdy[0] = 1'b1;
      #1;
      chk("mrst s_valid", o_sv[0], 0);
      chk("mrst grant", o_gnt[0], 0);
      chk("mrst busy", o_busy[0], 0);
      chk("mrst m_ready", o_rdy[0], 0);
      @(posedge clk); #1;
      tb_srdy[0] = 1'b0; tb_mv[0] = 2'b11;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst idle grant", o_gnt[0], 0);
      @(posedge clk); #1;
      tb_srdy[0] = 1'b1;
      @(negedge clk);
      chk("mrst first winner", o_gnt[0], 2'b01);
      chk("mrst first m_ready", o_rdy[0], 2'b01);
      @(posedge clk); #1;
      tb_mv[0] = '0; tb_srdy[0] = 1'b0;

      // ---- random traffic against the reference model
      do_reset();
      for (int d = 0; d < 2; d++) begin
         mbusy[d] = 0; own[d] = 0; lst[d] = NM - 1;
         for (int i = 0; i < NM; i++) pend[d][i] = 1'b0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NM; i++) begin
               if (!pend[d][i] && $urandom_range(0, 2) == 0) begin
                  pend[d][i] = 1'b1;
                  tb_ma[d][i*AW +: AW] = $urandom;
                  tb_mw[d][i*DW +: DW] = $urandom;
                  tb_ms[d][i*NB +: NB] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
               end else if (pend[d][i] && mbusy[d] == 1 && own[d] == i &&
                            $urandom_range(0, 3) == 0) begin
                  // fields change after grant; the captured copy must not
                  tb_ma[d][i*AW +: AW] = $urandom;
                  tb_mw[d][i*DW +: DW] = $urandom;
               end
               tb_mv[d][i] = pend[d][i];
            end
            tb_srdy[d] = ($urandom_range(0, 2) == 0);
            tb_sr[d]   = $urandom;
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            exp_gr  = (mbusy[d] == 1) ? (NM'(1) << own[d]) : '0;
            exp_rdy = tb_srdy[d] ? exp_gr : '0;
            chk($sformatf("rnd%0d c%0d grant", d, cyc), o_gnt[d], exp_gr);
            chk($sformatf("rnd%0d c%0d m_ready", d, cyc), o_rdy[d], exp_rdy);
            chk($sformatf("rnd%0d c%0d busy", d, cyc), o_busy[d], 64'(mbusy[d]));
            chk($sformatf("rnd%0d c%0d s_valid", d, cyc), o_sv[d], 64'(mbusy[d]));
            if (mbusy[d] == 1) begin
               chk($sformatf("rnd%0d c%0d s_addr", d, cyc), o_sa[d], caddr[d]);
               chk($sformatf("rnd%0d c%0d s_wdata", d, cyc), o_sw[d], cwd[d]);
               chk($sformatf("rnd%0d c%0d s_wstrb", d, cyc), o_ss[d], cst[d]);
            end
            if (exp_rdy != 0)
               chk($sformatf("rnd%0d c%0d m_rdata", d, cyc), o_rdata[d], tb_sr[d]);
            // advance the model to the next edge
            if (mbusy[d] == 1) begin
               if (tb_srdy[d]) begin
                  mbusy[d] = 0;
                  lst[d] = own[d];
                  pend[d][own[d]] = 1'b0;
               end
            end else if (tb_mv[d] != 0) begin
               own[d]   = pick(d, tb_mv[d], lst[d]);
               mbusy[d] = 1;
               caddr[d] = tb_ma[d][own[d]*AW +: AW];
               cwd[d]   = tb_mw[d][own[d]*DW +: DW];
               cst[d]   = tb_ms[d][own[d]*NB +: NB];
            end
         end
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
